// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction at a time over a req/ack handshake,
// issues it to decode and resolves jump-class opcodes against register-file operands.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [2:0]  JUMP_CLASS = 3'b110,
    parameter logic [4:0]  HALT_OP    = 5'b11111,
    parameter bit          SIGNED_CMP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        stall,
    output logic        fetch_req,
    output logic [15:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [15:0] fetch_data,
    output logic        instr_valid,
    output logic [15:0] instr,
    input  logic        issue_ready,
    input  logic        branch_valid,
    input  logic [15:0] operand_a,
    input  logic [15:0] operand_b,
    input  logic [15:0] target,
    output logic [15:0] pc,
    output logic        taken,
    output logic        halted
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        RESOLVE,
        HALT
    } state_t;

    state_t      state, state_next;
    logic [15:0] pc_next, instr_next, pc_inc;
    logic        taken_next;
    logic        a_gt_b, a_lt_b, cond;
    logic [4:0]  op;

    assign op     = instr[15:11];
    assign pc_inc = pc + 16'd1;

    always_comb begin
        if (SIGNED_CMP) begin
            a_gt_b = $signed(operand_a) > $signed(operand_b);
            a_lt_b = $signed(operand_a) < $signed(operand_b);
        end else begin
            a_gt_b = operand_a > operand_b;
            a_lt_b = operand_a < operand_b;
        end
        case (op[1:0])
            2'b00:   cond = a_gt_b;
            2'b01:   cond = a_lt_b;
            2'b10:   cond = (operand_a == operand_b);
            default: cond = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        taken_next = 1'b0;
        case (state)
            IDLE: begin
                if (run && !stall) state_next = FETCH;
            end
            // An ack always wins over stall once the request is outstanding.
            FETCH: begin
                if (fetch_ack) begin
                    instr_next = fetch_data;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ready) begin
                    if (op == HALT_OP) begin
                        pc_next    = pc_inc;
                        state_next = HALT;
                    end else if (op[4:2] == JUMP_CLASS) begin
                        state_next = RESOLVE;
                    end else begin
                        pc_next    = pc_inc;
                        state_next = stall ? IDLE : FETCH;
                    end
                end
            end
            RESOLVE: begin
                if (branch_valid) begin
                    pc_next    = cond ? target : pc_inc;
                    taken_next = cond;
                    state_next = stall ? IDLE : FETCH;
                end
            end
            HALT: begin
                if (run && !stall) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            instr <= '0;
            taken <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            instr <= instr_next;
            taken <= taken_next;
        end
    end

    assign fetch_req   = (state == FETCH);
    assign fetch_addr  = pc;
    assign instr_valid = (state == ISSUE);
    assign halted      = (state == HALT);

endmodule
